imem_arbiter: RTL and testbench

//  Shares one single-port synchronous instruction SRAM (1-cycle read latency) between the fetch stage and a

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_starve_ctr.sv | 38 +++
 rtl/imem_arbiter.sv | 105 ++++++++++
 tb/tb_imem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Owner tags, the in-flight record and the address legality check live here.
package imem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } imem_owner_e;

    // Record of the single access granted last cycle; its response is due now.
    typedef struct packed {
        imem_owner_e owner;
        logic        is_write;
        logic        bad;
    } imem_inflight_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A byte address is unusable if it is not word aligned or indexes past the SRAM.
    function automatic logic imem_addr_bad(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr[63:2] >= 62'(depth));
    endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating loss counter for the loader port.
// Once the loader has lost STARVE_MAX times in a row it is forced a grant.
module imem_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic force_grant
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg < CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign force_grant = (count_reg >= CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction SRAM arbiter between the fetch stage and a loader/debug port.
// One grant per cycle; the owner of the in-flight access receives the response one cycle later.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned STARVE_MAX = 4,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_mode,

    input  logic             f_req_valid,
    output logic             f_req_ready,
    input  logic [63:0]      f_addr,
    output logic             f_rsp_valid,
    output logic [31:0]      f_rsp_data,
    output logic             f_rsp_err,

    input  logic             l_req_valid,
    output logic             l_req_ready,
    input  logic             l_we,
    input  logic [63:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_rsp_valid,
    output logic [31:0]      l_rsp_data,
    output logic             l_rsp_err,

    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    logic           force_l;
    logic           f_bad;
    logic           l_bad;
    imem_inflight_t inflight_reg;
    imem_inflight_t inflight_next;

    imem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (l_req_valid && !l_req_ready),
        .clr         (l_req_ready),
        .force_grant (force_l)
    );

    assign f_bad = imem_addr_bad(f_addr, DEPTH);
    assign l_bad = imem_addr_bad(l_addr, DEPTH);

    // Ready already includes valid, so ready alone marks an accept.
    assign f_req_ready = f_req_valid && !load_mode && !force_l;
    assign l_req_ready = l_req_valid && !f_req_ready;

    // Bad requests are accepted and answered, but never touch the SRAM.
    always_comb begin
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_idx       = f_addr[IDX_W+1:2];
        mem_wdata     = '0;
        inflight_next = '{owner: OWN_NONE, is_write: 1'b0, bad: 1'b0};
        if (f_req_ready) begin
            inflight_next = '{owner: OWN_FETCH, is_write: 1'b0, bad: f_bad};
            mem_en        = !f_bad;
        end else if (l_req_ready) begin
            inflight_next = '{owner: OWN_LOAD, is_write: l_we, bad: l_bad};
            mem_en        = !l_bad;
            mem_we        = !l_bad && l_we;
            mem_idx       = l_addr[IDX_W+1:2];
            mem_wdata     = (!l_bad && l_we) ? l_wdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '{owner: OWN_NONE, is_write: 1'b0, bad: 1'b0};
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    // Responses are decoded straight from the in-flight record, so reset kills them at once.
    always_comb begin
        f_rsp_valid = (inflight_reg.owner == OWN_FETCH);
        f_rsp_data  = 32'h0;
        f_rsp_err   = 1'b0;
        l_rsp_valid = (inflight_reg.owner == OWN_LOAD);
        l_rsp_data  = 32'h0;
        l_rsp_err   = 1'b0;
        if (f_rsp_valid) begin
            f_rsp_err  = inflight_reg.bad;
            f_rsp_data = inflight_reg.bad ? NOP_INSTR : mem_rdata;
        end
        if (l_rsp_valid) begin
            l_rsp_err  = inflight_reg.bad;
            l_rsp_data = (inflight_reg.bad || inflight_reg.is_write) ? 32'h0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a transaction-level reference model.
module tb_imem_arbiter;

    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_mode = 1'b0;
    logic             f_req_valid = 1'b0;
    logic             f_req_ready;
    logic [63:0]      f_addr = '0;
    logic             f_rsp_valid;
    logic [31:0]      f_rsp_data;
    logic             f_rsp_err;
    logic             l_req_valid = 1'b0;
    logic             l_req_ready;
    logic             l_we = 1'b0;
    logic [63:0]      l_addr = '0;
    logic [31:0]      l_wdata = '0;
    logic             l_rsp_valid;
    logic [31:0]      l_rsp_data;
    logic             l_rsp_err;
    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = '0;

    always #5 clk = ~clk;

    imem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_mode   (load_mode),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_addr      (f_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .l_req_valid (l_req_valid),
        .l_req_ready (l_req_ready),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_rsp_valid (l_rsp_valid),
        .l_rsp_data  (l_rsp_data),
        .l_rsp_err   (l_rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_idx     (mem_idx),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // SRAM macro stand-in: one-cycle registered read.
    logic [31:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_idx] <= mem_wdata;
            else        mem_rdata     <= sram[mem_idx];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          ref_cnt;
    logic        pend_f, pend_f_err, pend_l, pend_l_err;
    logic [31:0] pend_f_data, pend_l_data;
    logic        last_f_ready;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 64'(DEPTH));
    endfunction

    function automatic logic [63:0] rand_addr();
        int unsigned r;
        logic [63:0] idx;
        r   = $urandom_range(0, 19);
        idx = 64'($urandom_range(0, 15));
        if (r == 0) return idx * 4 + 64'($urandom_range(1, 3));
        if (r == 1) return 64'(DEPTH) * 4 + idx * 4;
        if (r == 2) return {$urandom, $urandom} & ~64'h3 | 64'h0001_0000_0000_0000;
        if (r == 3) return 64'($urandom_range(0, DEPTH - 1)) * 4;
        return idx * 4;
    endfunction

    // One clock: check responses owed from last cycle, drive, check grant side, advance model.
    task automatic step(input logic fv, input logic [63:0] fa, input logic lm,
                        input logic lv, input logic lwe, input logic [63:0] la,
                        input logic [31:0] lwd);
        logic        e_force, e_fr, e_lr, fb, lb, e_en, e_we;
        logic [63:0] e_idx;
        check_eq("f_rsp_valid", f_rsp_valid, pend_f);
        if (pend_f) begin
            check_eq("f_rsp_data", f_rsp_data, pend_f_data);
            check_eq("f_rsp_err", f_rsp_err, pend_f_err);
        end
        check_eq("l_rsp_valid", l_rsp_valid, pend_l);
        if (pend_l) begin
            check_eq("l_rsp_data", l_rsp_data, pend_l_data);
            check_eq("l_rsp_err", l_rsp_err, pend_l_err);
        end

        f_req_valid = fv; f_addr = fa; load_mode = lm;
        l_req_valid = lv; l_we = lwe; l_addr = la; l_wdata = lwd;
        #1;

        e_force = (ref_cnt >= STARVE_MAX);
        e_fr    = fv && !lm && !e_force;
        e_lr    = lv && !e_fr;
        fb      = addr_bad(fa);
        lb      = addr_bad(la);
        e_en    = (e_fr && !fb) || (e_lr && !lb);
        e_we    = e_lr && !lb && lwe;
        e_idx   = e_fr ? (fa >> 2) : (la >> 2);
        last_f_ready = f_req_ready;
        check_eq("f_req_ready", f_req_ready, e_fr);
        check_eq("l_req_ready", l_req_ready, e_lr);
        check_eq("mem_en", mem_en, e_en);
        if (e_en) begin
            check_eq("mem_we", mem_we, e_we);
            check_eq("mem_idx", 64'(mem_idx), e_idx);
            if (e_we) check_eq("mem_wdata", mem_wdata, lwd);
        end

        if (e_fr) $display("[%0t] fetch addr=%h bad=%0b", $time, fa, fb);
        if (e_lr) $display("[%0t] load  %s addr=%h bad=%0b wdata=%h", $time, lwe ? "wr" : "rd", la, lb, lwd);

        pend_f = e_fr; pend_f_err = fb; pend_f_data = NOP;
        if (e_fr && !fb) pend_f_data = ref_mem[int'(fa >> 2)];
        pend_l = e_lr; pend_l_err = lb; pend_l_data = 32'h0;
        if (e_lr && !lb) begin
            if (lwe) ref_mem[int'(la >> 2)] = lwd;
            else     pend_l_data = ref_mem[int'(la >> 2)];
        end
        if (e_lr) ref_cnt = 0;
        else if (lv && ref_cnt < STARVE_MAX) ref_cnt++;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            sram[i]    = ref_mem[i];
        end
        ref_mem[0] = 32'h0050_0093;
        sram[0]    = 32'h0050_0093;
        ref_cnt = 0;
        pend_f = 0; pend_l = 0; pend_f_err = 0; pend_l_err = 0;
        pend_f_data = '0; pend_l_data = '0; last_f_ready = 0;

        repeat (2) @(negedge clk);
        check_eq("rst_f_valid", f_rsp_valid, 1'b0);
        check_eq("rst_f_data", f_rsp_data, 32'h0);
        check_eq("rst_f_err", f_rsp_err, 1'b0);
        check_eq("rst_l_valid", l_rsp_valid, 1'b0);
        check_eq("rst_l_data", l_rsp_data, 32'h0);
        rst_n = 1'b1;

        // Basic fetch of word 0.
        step(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_eq("t1_data", f_rsp_data, 32'h0050_0093);
        idle();

        // Contention: loader forced through on the fifth contended cycle only.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 64'(i * 4), 1'b0, 1'b1, 1'b0, 64'h20, 32'h0);
            check_eq("t2_stall", last_f_ready, (i == 4) ? 1'b0 : 1'b1);
        end
        idle();

        // Load mode write then read-back.
        step(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 64'h10, 32'hDEAD_BEEF);
        check_eq("t3_fblk", last_f_ready, 1'b0);
        check_eq("t3_ack", l_rsp_data, 32'h0);
        step(1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 64'h10, 32'h0);
        check_eq("t3_fblk", last_f_ready, 1'b0);
        check_eq("t3_rdata", l_rsp_data, 32'hDEAD_BEEF);
        idle();

        // Misaligned and out-of-range fetches.
        step(1'b1, 64'h2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_eq("t4_mis_data", f_rsp_data, NOP);
        check_eq("t4_mis_err", f_rsp_err, 1'b1);
        step(1'b1, 64'(DEPTH) * 4, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_eq("t4_oor_data", f_rsp_data, NOP);
        check_eq("t4_oor_err", f_rsp_err, 1'b1);
        idle();

        // Reset mid-cycle with a loader read in flight.
        load_mode = 1'b1; l_req_valid = 1'b1; l_we = 1'b0; l_addr = 64'h10; f_req_valid = 1'b0;
        @(posedge clk);
        #2;
        check_eq("t5_pre_valid", l_rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_l_valid", l_rsp_valid, 1'b0);
        check_eq("t5_f_valid", f_rsp_valid, 1'b0);
        check_eq("t5_l_data", l_rsp_data, 32'h0);
        load_mode = 1'b0; l_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pend_f = 0; pend_l = 0; ref_cnt = 0;
        repeat (3) idle();

        // Back-to-back fetches with no bubbles.
        step(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        step(1'b1, 64'h4, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_eq("t6_v0", f_rsp_valid, 1'b1);
        step(1'b1, 64'h8, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_eq("t6_v1", f_rsp_valid, 1'b1);
        idle();

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), rand_addr(), $urandom);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
